load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of addr/mem_A.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width of wdata/rdata/mem_WD/mem_RD.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  1  core access request; sampled only in IDLE.
REQ-006 SHALL have port store  input  1  1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port addr  input  ADDR_WIDTH  byte address; sampled with req.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  store data, LSB-aligned; sampled with req.
REQ-010 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; access aborted.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  extended load result; held until next done.
REQ-014 SHALL have port mem_A  output  ADDR_WIDTH  word-aligned memory address, {addr[ADDR_WIDTH-1:2],2'b00}.
REQ-015 SHALL have port mem_WD  output  DATA_WIDTH  merged write word.
REQ-016 SHALL have port mem_WE  output  1  memory write enable; memory writes on posedge CLK.
REQ-017 SHALL have port mem_RD  input  DATA_WIDTH  combinational read data for mem_A.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 SHALL, in IDLE with req=1, latch store/funct3/addr/wdata and transition: load -> READ; store with funct3=010 -> WRITE; store with 000/001 -> READ; fault -> DONE with err.
REQ-020 SHALL, in READ, capture mem_RD into a word register, then go to WRITE for stores or DONE for loads.
REQ-021 SHALL, in WRITE, assert mem_WE for exactly that one cycle, then go to DONE.
REQ-022 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE; a req in that cycle is ignored.
REQ-023 SHALL drive mem_WE=0 in every state except WRITE; mem_A SHALL hold the latched aligned address from READ through DONE.
REQ-024 SHALL have latencies, from the req cycle N: load done at N+2; SW done at N+2; SB/SH done at N+3 via read-modify-write; fault done at N+1.
REQ-025 SHALL select the load lane by addr[1:0] (byte) or addr[1] (half); sign-extend for B/H and zero-extend for BU/HU; W passes the word unchanged.
REQ-026 SHALL, for SB/SH, build mem_WD from the captured word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
REQ-027 SHALL treat funct3 011/110/111, and store with funct3 100/101, as illegal -> err=1, no memory access.
REQ-028 SHALL ignore req while busy=1.
REQ-029 SHALL leave rdata unchanged on stores and on err completions.

Reset
REQ-030 SHALL, on RST=1 at posedge CLK, go to IDLE with busy=0, done=0, err=0, mem_WE=0, rdata=0, mem_A=0, mem_WD=0.
REQ-031 SHALL abort an in-flight access on reset: no done pulse, and no mem_WE for the aborted access on or after the reset edge.
REQ-032 SHALL give RST priority over req in the same cycle.

Configuration
REQ-033 SHALL, when LSU_MISALIGN_CHECK_EN is defined, fault H/HU with addr[0]=1 and W with addr[1:0]!=0: err=1, done at N+1, no memory access.
REQ-034 SHALL, without LSU_MISALIGN_CHECK_EN, never raise err for alignment; W ignores addr[1:0], and H/HU ignore addr[0].

Verification
REQ-035 SHALL pass: memory word 0x8 = 0x80FF_1234; LB addr 0x9 -> done at N+2, rdata=0x0000_0012; LBU addr 0xB -> rdata=0x0000_0080; LH addr 0xA -> rdata=0xFFFF_80FF.
REQ-036 SHALL pass: word 0x4 = 0xAABB_CCDD; SB addr 0x5 wdata 0x0000_0011 -> one mem_WE cycle at N+2, mem_WD=0xAABB_11DD; done at N+3.
REQ-037 SHALL pass: SW addr 0x10 wdata 0xDEAD_BEEF -> mem_WE only at N+1, mem_A=0x10; a following LW 0x10 -> rdata=0xDEAD_BEEF.
REQ-038 SHALL pass (macro defined): LW addr 0x6 -> err=1 and done at N+1, mem_WE never high; (macro undefined): same access returns the word at 0x4 with err=0.
REQ-039 SHALL pass: RST asserted during READ of an SH -> IDLE next cycle, mem_WE never asserted, no done, memory word unchanged.
REQ-040 SHALL pass: req held high continuously -> accesses accepted only in IDLE, one done per accepted access.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I byte/half/word load-store unit: single-port word memory, read-modify-write for SB/SH.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned H/HU/W accesses instead of ignoring low address bits.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req,
    input  logic                  store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    store_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q;
    logic                    fault;
    logic                    illegal;
    logic                    misalign;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   wd_merge;

    assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign fault = illegal || misalign;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (fault)                  state_d = DONE;
                    else if (!store)            state_d = READ;
                    else if (funct3 == 3'b010)  state_d = WRITE;
                    else                        state_d = READ;
                end
            end
            READ:    state_d = store_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection for loads works straight off mem_RD so rdata is ready at the DONE cycle
    assign ld_byte = mem_RD[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = mem_RD[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        rdata_d = mem_RD;
        case (f3_q)
            3'b000:  rdata_d = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  rdata_d = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  rdata_d = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  rdata_d = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: rdata_d = mem_RD;
        endcase
    end

    always_comb begin
        wd_merge = word_q;
        case (f3_q)
            3'b000:  wd_merge[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            3'b001:  wd_merge[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: wd_merge = wdata_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                store_q <= store;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= fault;
            end
            if (state_q == READ) begin
                word_q <= mem_RD;
                if (!store_q) rdata_q <= rdata_d;
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign err    = (state_q == DONE) && err_q;
    assign mem_WE = (state_q == WRITE);
    assign mem_A  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_WD = wd_merge;
    assign rdata  = rdata_q;

endmodule
